eval_sched: RTL and testbench
=============================

Name: eval_sched

Overview:
- Hardware scheduler that sequences evaluation of NPROC sensitivity-triggered processes onto one shared evaluator.
- Sources raise trigger pulses. The block keeps a deduplicated pending set and grants one process at a time, round-robin, over a valid/ready dispatch handshake.
- It waits for the evaluator's completion before dispatching the next process, and reports quiescence when nothing is pending or running.
- Sits between the trigger-detection logic and the single evaluator datapath.

Parameters:
- NPROC, 8, number of schedulable processes (2..32).
- IDW, $clog2(NPROC), width of a process id.
- CNTW, 16, width of the dispatch counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- trig  in  NPROC  per-process trigger; each bit is a one-cycle request to evaluate that process.
- disp_valid  out  1  dispatch offer valid.
- disp_ready  in  1  evaluator accepts the offer.
- disp_id  out  IDW  id of the offered process.
- eval_done  in  1  one-cycle pulse; evaluator finished the running process.
- running_id  out  IDW  id of the process currently being evaluated.
- pending  out  NPROC  registered pending set.
- busy  out  1  high when state is not IDLE.
- quiet  out  1  one-cycle pulse on the RUN->IDLE transition.
- dispatch_cnt  out  CNTW  number of accepted dispatches.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, any time, including mid-RUN): state=IDLE, pending=0, disp_valid=0, disp_id=0, running_id=0, rr_ptr=0, dispatch_cnt=0, quiet=0, err=0. An in-flight evaluation is abandoned.
- Pending update each cycle: pending_next = (pending | trig_eff) & ~grant_mask.
  - trig_eff = trig with the running_id bit masked while in RUN.
  - grant_mask = onehot(disp_id) on the cycle of handshake (disp_valid & disp_ready).
- Deduplication: triggering an already-pending id has no effect. One id never holds two entries.
- Round-robin pick: the first set bit of the candidate set, scanning upward from rr_ptr and wrapping NPROC-1 -> 0.
- After each handshake, rr_ptr = (disp_id+1) mod NPROC.
- FSM has three states: IDLE, OFFER, RUN.
- IDLE:
  - If (pending|trig) != 0, go to OFFER and register disp_id = pick(pending|trig).
  - disp_valid=1 from the next cycle, so trigger-to-offer latency is 1 cycle.
- OFFER:
  - disp_valid=1. disp_id is held stable until handshake, even if higher-priority triggers arrive.
  - On handshake: running_id=disp_id, dispatch_cnt increments (wraps at 2^CNTW), go to RUN. disp_valid drops the next cycle.
- RUN:
  - disp_valid=0.
  - On eval_done: if pending_next != 0, go to OFFER with disp_id = pick(pending_next) (offer 1 cycle after done). Otherwise go to IDLE and pulse quiet for 1 cycle.
- Simultaneous events:
  - A trigger of disp_id on its handshake cycle is dropped, because that id becomes running.
  - A trigger arriving on the eval_done cycle is included in the next pick.
- err sets on any of:
  - eval_done when state != RUN;
  - disp_ready while disp_valid=0 is NOT an error (ready may idle high).
- pending can never overflow: the set has at most NPROC bits by construction.

Optional Feature:
- Macro SELF_RETRIG_EN.
- Defined: trig_eff = trig unmasked. A trigger of running_id during RUN sets its pending bit, so that process is re-dispatched after completion, subject to round-robin order.
- Undefined (default): a trigger of running_id while in RUN is discarded. This matches a process that is not waiting at its event control while executing.

Test Plan:
- Reset mid-operation:
  - Stimulus: trig=8'h05, hold disp_ready=1, assert rst during RUN.
  - Required: outputs return to reset values asynchronously, pending=0, and no offer after rst deasserts.
- Single trigger, ready=1:
  - Stimulus: trig=8'h10 at cycle 0; eval_done 3 cycles after handshake.
  - Required: disp_valid=1 with disp_id=4 at cycle 1; running_id=4; quiet pulses 1 cycle after eval_done; dispatch_cnt=1.
- Round-robin order:
  - Stimulus: trig=8'h83 at once, then eval_done after each dispatch.
  - Required: dispatch order 0,1,7.
  - Stimulus: then trig=8'h81 with rr_ptr=0.
  - Required: order 0,7.
- Dedup and stall:
  - Stimulus: disp_ready=0 for 5 cycles while trig bit 2 pulses 3 times.
  - Required: disp_id stays 2, pending[2] is set exactly once, and one dispatch only.
- Self-retrigger:
  - Stimulus: trig bit 3 during RUN of id 3.
  - Required without SELF_RETRIG_EN: IDLE plus a quiet pulse after eval_done.
  - Required with SELF_RETRIG_EN: id 3 re-offered 1 cycle after eval_done; dispatch_cnt=2.
- Protocol error:
  - Stimulus: eval_done in IDLE.
  - Required: err=1, and it stays 1 until rst.

Source files
------------

// File: rtl/eval_sched_if.sv
// Dispatch/completion handshake between the scheduler (master) and the
// shared evaluator (slave).
interface eval_sched_if #(
    parameter int IDW = 3
);
    logic           disp_valid;
    logic           disp_ready;
    logic [IDW-1:0] disp_id;
    logic           eval_done;
    logic [IDW-1:0] running_id;

    modport master (
        output disp_valid,
        output disp_id,
        output running_id,
        input  disp_ready,
        input  eval_done
    );

    modport slave (
        input  disp_valid,
        input  disp_id,
        input  running_id,
        output disp_ready,
        output eval_done
    );
endinterface

// File: rtl/eval_sched.sv
// Round-robin scheduler of NPROC triggered processes onto one evaluator.
// Optional macro SELF_RETRIG_EN: let a running process re-arm itself.
module eval_sched #(
    parameter int NPROC = 8,
    parameter int IDW   = $clog2(NPROC),
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPROC-1:0] trig,
    eval_sched_if.master     dif,
    output logic [NPROC-1:0] pending,
    output logic             busy,
    output logic             quiet,
    output logic [CNTW-1:0]  dispatch_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NPROC-1:0] pending_q, pending_d;
    logic [IDW-1:0]   disp_id_q, disp_id_d;
    logic [IDW-1:0]   running_id_q, running_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             disp_valid_q, disp_valid_d;
    logic             busy_q, busy_d;
    logic             quiet_q, quiet_d;
    logic             err_q, err_d;

    logic             handshake_s;
    logic [NPROC-1:0] trig_eff_s;
    logic [NPROC-1:0] grant_mask_s;

    function automatic logic [NPROC-1:0] onehot(input logic [IDW-1:0] id);
        logic [NPROC-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // First set bit of cand at or above ptr, wrapping past NPROC-1 to 0.
    function automatic logic [IDW-1:0] pick(input logic [NPROC-1:0] cand,
                                            input logic [IDW-1:0]   ptr);
        logic [IDW-1:0] sel;
        logic [IDW-1:0] cur;
        logic           found;
        int             idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NPROC; k++) begin
            idx = (int'(ptr) + k) % NPROC;
            cur = IDW'(idx);
            if (!found && cand[cur]) begin
                sel   = cur;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    // Next-state, pending-set and counter computation.
    always_comb begin
        state_d      = state_q;
        disp_id_d    = disp_id_q;
        running_id_d = running_id_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        quiet_d      = 1'b0;

        handshake_s  = disp_valid_q & dif.disp_ready;
`ifdef SELF_RETRIG_EN
        trig_eff_s   = trig;
`else
        if (state_q == ST_RUN) begin
            trig_eff_s = trig & ~onehot(running_id_q);
        end else begin
            trig_eff_s = trig;
        end
`endif
        if (handshake_s) begin
            grant_mask_s = onehot(disp_id_q);
        end else begin
            grant_mask_s = '0;
        end
        pending_d = (pending_q | trig_eff_s) & ~grant_mask_s;
        err_d     = err_q | (dif.eval_done & (state_q != ST_RUN));

        case (state_q)
            ST_IDLE: begin
                if ((pending_q | trig) != '0) begin
                    state_d   = ST_OFFER;
                    disp_id_d = pick(pending_q | trig, rr_ptr_q);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (handshake_s) begin
                    state_d      = ST_RUN;
                    running_id_d = disp_id_q;
                    cnt_d        = cnt_q + CNTW'(1);
                    if (disp_id_q == IDW'(NPROC - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = disp_id_q + IDW'(1);
                    end
                end else begin
                    state_d = ST_OFFER;
                end
            end
            ST_RUN: begin
                if (dif.eval_done && (pending_d != '0)) begin
                    state_d   = ST_OFFER;
                    disp_id_d = pick(pending_d, rr_ptr_q);
                end else if (dif.eval_done) begin
                    state_d = ST_IDLE;
                    quiet_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        disp_valid_d = (state_d == ST_OFFER);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset abandons any in-flight evaluation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            disp_id_q    <= '0;
            running_id_q <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            quiet_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            disp_id_q    <= disp_id_d;
            running_id_q <= running_id_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
            quiet_q      <= quiet_d;
            err_q        <= err_d;
        end
    end

    assign dif.disp_valid = disp_valid_q;
    assign dif.disp_id    = disp_id_q;
    assign dif.running_id = running_id_q;
    assign pending        = pending_q;
    assign busy           = busy_q;
    assign quiet          = quiet_q;
    assign dispatch_cnt   = cnt_q;
    assign err            = err_q;

endmodule

// File: tb/tb_eval_sched.sv
// Directed and randomized checks of eval_sched against a set-based model.
module tb_eval_sched;
    localparam int NPROC = 8;
    localparam int IDW   = 3;
    localparam int CNTW  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NPROC-1:0] trig;
    logic [NPROC-1:0] pending;
    logic             busy, quiet, err;
    logic [CNTW-1:0]  dispatch_cnt;

    eval_sched_if #(.IDW(IDW)) dif ();

    eval_sched #(.NPROC(NPROC), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .trig(trig), .dif(dif), .pending(pending),
        .busy(busy), .quiet(quiet), .dispatch_cnt(dispatch_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a set of waiting ids, an offer slot and a running slot.
    logic [NPROC-1:0] m_pend;
    int  m_rr, m_offer_id, m_run_id, m_cnt;
    bit  m_offer, m_active, m_quiet, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input logic [NPROC-1:0] s, input int from);
        for (int k = 0; k < NPROC; k++) begin
            if (s[(from + k) % NPROC]) return (from + k) % NPROC;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_rr = 0; m_offer_id = 0; m_run_id = 0; m_cnt = 0;
        m_offer = 0; m_active = 0; m_quiet = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [NPROC-1:0] t, input logic r, input logic d);
        int id;
        bit hs;
        hs      = m_offer && r;
        m_quiet = 0;
        if (d && !m_active) m_err = 1;
        for (int i = 0; i < NPROC; i++) begin
`ifdef SELF_RETRIG_EN
            if (t[i]) m_pend[i] = 1'b1;
`else
            if (t[i] && !(m_active && i == m_run_id)) m_pend[i] = 1'b1;
`endif
        end
        if (hs) begin
            m_pend[m_offer_id] = 1'b0;
            m_run_id = m_offer_id;
            m_cnt    = (m_cnt + 1) % (1 << CNTW);
            m_rr     = (m_offer_id + 1) % NPROC;
            m_offer  = 0;
            m_active = 1;
        end else if (!m_offer && !m_active) begin
            id = rr_pick(m_pend, m_rr);
            if (id >= 0) begin m_offer = 1; m_offer_id = id; end
        end else if (m_active && d) begin
            m_active = 0;
            id = rr_pick(m_pend, m_rr);
            if (id >= 0) begin m_offer = 1; m_offer_id = id; end
            else m_quiet = 1;
        end
    endtask

    task automatic compare_all();
        chk("disp_valid", dif.disp_valid, m_offer);
        chk("disp_id", dif.disp_id, m_offer_id);
        chk("running_id", dif.running_id, m_run_id);
        chk("pending", pending, m_pend);
        chk("busy", busy, m_offer | m_active);
        chk("quiet", quiet, m_quiet);
        chk("dispatch_cnt", dispatch_cnt, m_cnt);
        chk("err", err, m_err);
    endtask

    task automatic step(input logic [NPROC-1:0] t, input logic r, input logic d);
        trig = t; dif.disp_ready = r; dif.eval_done = d;
        model_step(t, r, d);
        @(posedge clk); #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; trig = '0; dif.disp_ready = 1'b0; dif.eval_done = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        compare_all();
    endtask

    // Accept the current offer, run it three cycles and complete it.
    task automatic serve(output int id);
        id = -1;
        for (int w = 0; w < 10 && id < 0; w++) begin
            if (dif.disp_valid === 1'b1) id = int'(dif.disp_id);
            else step('0, 1'b1, 1'b0);
        end
        if (id >= 0) begin
            step('0, 1'b1, 1'b0);
            step('0, 1'b1, 1'b0);
            step('0, 1'b1, 1'b1);
        end
    endtask

    initial begin
        int id;
        logic [NPROC-1:0] t;
        logic r, d;

        // Reset state, checked asynchronously before any clock edge.
        rst = 1'b1; trig = '0; dif.disp_ready = 1'b0; dif.eval_done = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", dif.disp_valid, 1'b0);
        chk("rst_pending", pending, 8'h00);
        chk("rst_cnt", dispatch_cnt, 16'd0);
        chk("rst_err", err, 1'b0);
        do_reset();

        // Single trigger with ready high.
        step(8'h10, 1'b1, 1'b0);
        chk("single_valid", dif.disp_valid, 1'b1);
        chk("single_id", dif.disp_id, 3'd4);
        step('0, 1'b1, 1'b0);
        chk("single_running", dif.running_id, 3'd4);
        chk("single_cnt", dispatch_cnt, 16'd1);
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b1);
        chk("single_quiet", quiet, 1'b1);
        step('0, 1'b1, 1'b0);
        chk("single_quiet_end", quiet, 1'b0);

        // Round-robin order from rr_ptr = 0.
        do_reset();
        step(8'h83, 1'b1, 1'b0);
        serve(id); chk("rr_a0", id, 0);
        serve(id); chk("rr_a1", id, 1);
        serve(id); chk("rr_a7", id, 7);
        chk("rr_a_quiet", quiet, 1'b1);
        step(8'h81, 1'b1, 1'b0);
        serve(id); chk("rr_b0", id, 0);
        serve(id); chk("rr_b7", id, 7);
        chk("rr_ready_idle_err", err, 1'b0);

        // Dedup while the offer is stalled.
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        chk("dedup_id", dif.disp_id, 3'd2);
        chk("dedup_pending", pending, 8'h04);
        step('0, 1'b1, 1'b0);
        chk("dedup_cnt", dispatch_cnt, 16'd6);
        chk("dedup_pending_clr", pending, 8'h00);
        step('0, 1'b1, 1'b1);
        step('0, 1'b1, 1'b0);
        chk("dedup_no_reoffer", dif.disp_valid, 1'b0);

        // Self-retrigger of the running process.
        do_reset();
        step(8'h08, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        step(8'h08, 1'b1, 1'b0);
        step('0, 1'b1, 1'b1);
`ifdef SELF_RETRIG_EN
        chk("retrig_valid", dif.disp_valid, 1'b1);
        chk("retrig_id", dif.disp_id, 3'd3);
        step('0, 1'b1, 1'b0);
        chk("retrig_cnt", dispatch_cnt, 16'd2);
        step('0, 1'b1, 1'b1);
`else
        chk("noretrig_quiet", quiet, 1'b1);
        chk("noretrig_busy", busy, 1'b0);
`endif

        // Protocol error: completion while idle is sticky.
        do_reset();
        step('0, 1'b1, 1'b1);
        chk("err_set", err, 1'b1);
        step(8'h01, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        chk("err_sticky", err, 1'b1);

        // Reset asserted mid-RUN, away from the clock edge.
        do_reset();
        step(8'h05, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        chk("midrst_running", busy, 1'b1);
        #2; rst = 1'b1; #1;
        model_reset();
        chk("midrst_valid", dif.disp_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_pending", pending, 8'h00);
        chk("midrst_cnt", dispatch_cnt, 16'd0);
        chk("midrst_running_id", dif.running_id, 3'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step('0, 1'b1, 1'b0);
        chk("midrst_no_offer", dif.disp_valid, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            t = ($urandom_range(0, 2) == 0) ? NPROC'($urandom) : '0;
            r = ($urandom_range(0, 3) != 0);
            d = m_active && ($urandom_range(0, 2) == 0);
            step(t, r, d);
        end
        chk("rand_activity", dispatch_cnt > 16'd20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
